if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives it to the memory's address input. It captures the four returned instruction nibbles into the IF/ID pipeline register that feeds decode. It handles stalls, flushes, taken branches and, optionally, halt detection.

## Interface
- `PC_RESET`, default 16'h0000: PC value loaded on reset.
- `PC_STEP`, default 2: bytes per instruction; sequential PC increment.
- `HALT_OP`, default 4'hF: opcode nibble (`one`) that marks a halt instruction.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `one`, `two`, `three`, `four` in 4 each: instruction nibbles returned combinationally by instruction memory for the current `pc`.
- `stall` in 1: hazard unit request to hold the PC and the IF/ID register.
- `flush` in 1: insert a bubble into IF/ID; PC holds.
- `br_taken` in 1: a later stage resolved a taken branch or jump.
- `br_target` in 16: branch/jump destination byte address.
- `pc` out 16: fetch address to instruction memory; registered.
- `id_one`, `id_two`, `id_three`, `id_four` out 4 each: IF/ID instruction nibbles; registered.
- `id_pc` out 16: address of the instruction held in IF/ID.
- `id_valid` out 1: IF/ID holds a real instruction; 0 means bubble/NOP.
- `halted` out 1: fetch is in the HALT state.

## Operation
- States are RUN and HALT. Reset enters RUN.
- Per-edge priority: reset > `br_taken` > `flush` > `stall` > halt detect > normal.
- **`br_taken`** (any state, overrides `stall`):
  - `pc <= {br_target[15:1],1'b0}`; an odd target is forced even.
  - IF/ID becomes a bubble: `id_valid<=0`, nibbles `<=0`, `id_pc<=0`.
  - State goes to RUN.
- **`flush`** without `br_taken`: IF/ID becomes a bubble; `pc` and state hold.
- **`stall`** without `br_taken`/`flush`: `pc`, IF/ID and state all hold unchanged.
- **Normal, RUN:**
  - `pc <= pc + PC_STEP`, modulo 2^16, so 0xFFFE wraps to 0x0000.
  - `id_one..id_four <= one..four`, `id_pc <= pc`, `id_valid <= 1`.
- **Halt detect** (RUN, no stall/flush/branch, `one == HALT_OP`):
  - The halt instruction is latched into IF/ID with `id_valid=1`.
  - `pc` holds (not incremented) and the state goes to HALT.
- **HALT:**
  - `pc` holds.
  - Every non-stall edge loads a bubble into IF/ID.
  - Only `br_taken` or reset leaves HALT.
- `halted` = (state == HALT).
- Reset asserted mid-operation immediately returns every register to its reset value, with no clock required.

## Timing
- Reset values: `pc=PC_RESET`, `id_one..id_four=0`, `id_pc=0`, `id_valid=0`, `halted=0`, state RUN.
- `pc` is a register, and memory returns nibbles combinationally in the same cycle.
- Fetch-to-IF/ID latency: 1 edge.
- Branch penalty: 1 bubble. The edge that sees `br_taken` loads the bubble; the next edge captures the target instruction.
- `stall` held for N cycles freezes the outputs for exactly N edges.
- The first edge after reset release captures the instruction at `PC_RESET`.

## Configuration
- `IF_HALT_EN` defined: the HALT state and `HALT_OP` detection are compiled in, as described above.
- `IF_HALT_EN` undefined:
  - There is no HALT state, and `HALT_OP` is an ordinary opcode; the PC keeps advancing.
  - `halted` is tied to 0.

## Test plan
- **Reset and first fetch:** release `rst` with memory bytes 0/1 = 01/2F. Required: the first edge gives `id`=0,1,2,F, `id_pc=0`, `id_valid=1`, `pc=2`.
- **Stall and flush:**
  - Assert `stall` for 3 cycles at `pc=4`: `pc` stays 4 and IF/ID holds for 3 edges.
  - Then pulse `flush`: `id_valid=0` and `pc` stays 4.
- **Taken branch:**
  - `br_taken=1`, `br_target=0x0025`, with `stall=1` at the same time: `pc=0x0024` and `id_valid=0`.
  - Next edge, with bytes 88/90: `id`=8,8,9,0 and `id_pc=0x0024`.
- **Halt** (with `IF_HALT_EN`):
  - Fetch bytes F0/00 at 0x0032: `id`=F,0,0,0 with `id_valid=1`, `halted=1`, `pc` stays 0x0032.
  - Following edges: `id_valid=0`.
  - Then `br_taken` to 0x0000: `halted=0` and `pc=0`.
- **Wrap:** branch to 0xFFFE, then one normal edge: `pc=0x0000`, `id_pc=0xFFFE`.
- **Async reset mid-run:** drop `rst` between edges at `pc=0x0010`. Required: `pc=0`, `id_valid=0`, `halted=0` before the next clock edge.

Source files
------------

// File: rtl/if_fetch_if.sv
// Fetch-to-instruction-memory bus: registered fetch address out,
// four combinational instruction nibbles back.
interface if_fetch_if;
  logic [15:0] pc;
  logic [3:0]  one;
  logic [3:0]  two;
  logic [3:0]  three;
  logic [3:0]  four;

  modport master (
    output pc,
    input  one, two, three, four
  );

  modport slave (
    input  pc,
    output one, two, three, four
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC and the IF/ID register.
// Define IF_HALT_EN to compile in HALT_OP detection and the HALT state.
module if_fetch #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter int unsigned PC_STEP  = 2,
  parameter logic [3:0]  HALT_OP  = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  if_fetch_if.master  mem,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic [3:0]  id_one,
  output logic [3:0]  id_two,
  output logic [3:0]  id_three,
  output logic [3:0]  id_four,
  output logic [15:0] id_pc,
  output logic        id_valid,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_n;
  logic [15:0] pc_q, pc_n;
  logic [3:0]  one_n, two_n, three_n, four_n;
  logic [15:0] id_pc_n;
  logic        valid_n;
  logic        halt_hit;

`ifdef IF_HALT_EN
  localparam bit HALT_EN = 1'b1;
  assign halted = (state == HALT);
`else
  localparam bit HALT_EN = 1'b0;
  assign halted = 1'b0;
`endif

  assign mem.pc   = pc_q;
  assign halt_hit = HALT_EN && (mem.one == HALT_OP);

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    one_n   = id_one;
    two_n   = id_two;
    three_n = id_three;
    four_n  = id_four;
    id_pc_n = id_pc;
    valid_n = id_valid;
    if (br_taken) begin
      pc_n    = {br_target[15:1], 1'b0};
      state_n = RUN;
      one_n   = 4'h0;
      two_n   = 4'h0;
      three_n = 4'h0;
      four_n  = 4'h0;
      id_pc_n = 16'h0000;
      valid_n = 1'b0;
    end else if (flush || (!stall && state == HALT)) begin
      // bubble; PC and state are left alone
      one_n   = 4'h0;
      two_n   = 4'h0;
      three_n = 4'h0;
      four_n  = 4'h0;
      id_pc_n = 16'h0000;
      valid_n = 1'b0;
    end else if (!stall) begin
      one_n   = mem.one;
      two_n   = mem.two;
      three_n = mem.three;
      four_n  = mem.four;
      id_pc_n = pc_q;
      valid_n = 1'b1;
      if (halt_hit) begin
        state_n = HALT;
      end else begin
        pc_n = pc_q + 16'(PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RUN;
      pc_q     <= PC_RESET;
      id_one   <= 4'h0;
      id_two   <= 4'h0;
      id_three <= 4'h0;
      id_four  <= 4'h0;
      id_pc    <= 16'h0000;
      id_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc_q     <= pc_n;
      id_one   <= one_n;
      id_two   <= two_n;
      id_three <= three_n;
      id_four  <= four_n;
      id_pc    <= id_pc_n;
      id_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: vector table plus reset corner cases.
// Nibbles are driven straight onto the memory bus per vector.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [15:0] br_target;
  logic [3:0]  id_one, id_two, id_three, id_four;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        halted;

  if_fetch_if mem ();

  if_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .mem       (mem),
    .stall     (stall),
    .flush     (flush),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_one    (id_one),
    .id_two    (id_two),
    .id_three  (id_three),
    .id_four   (id_four),
    .id_pc     (id_pc),
    .id_valid  (id_valid),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        fl;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] nib;
    logic [15:0] e_pc;
    logic [15:0] e_id;
    logic [15:0] e_idpc;
    logic        e_v;
    logic        e_h;
  } vec_t;

  localparam int NV = 20;
  vec_t vt[NV];

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] ids();
    return {id_one, id_two, id_three, id_four};
  endfunction

  initial begin
    // st fl br tgt nib | pc id id_pc v h
    vt[0]  = '{0,0,0,16'h0000,16'h012F, 16'h0002,16'h012F,16'h0000,1,0};
    vt[1]  = '{0,0,0,16'h0000,16'h3456, 16'h0004,16'h3456,16'h0002,1,0};
    vt[2]  = '{1,0,0,16'h0000,16'h7777, 16'h0004,16'h3456,16'h0002,1,0};
    vt[3]  = '{1,0,0,16'h0000,16'h7777, 16'h0004,16'h3456,16'h0002,1,0};
    vt[4]  = '{1,0,0,16'h0000,16'h7777, 16'h0004,16'h3456,16'h0002,1,0};
    vt[5]  = '{0,1,0,16'h0000,16'h7777, 16'h0004,16'h0000,16'h0000,0,0};
    vt[6]  = '{0,0,0,16'h0000,16'hABCD, 16'h0006,16'hABCD,16'h0004,1,0};
    vt[7]  = '{1,0,1,16'h0025,16'h1111, 16'h0024,16'h0000,16'h0000,0,0};
    vt[8]  = '{0,0,0,16'h0000,16'h8890, 16'h0026,16'h8890,16'h0024,1,0};
    vt[9]  = '{0,0,1,16'h0032,16'h5555, 16'h0032,16'h0000,16'h0000,0,0};
`ifdef IF_HALT_EN
    vt[10] = '{0,0,0,16'h0000,16'hF000, 16'h0032,16'hF000,16'h0032,1,1};
    vt[11] = '{0,0,0,16'h0000,16'h1234, 16'h0032,16'h0000,16'h0000,0,1};
    vt[12] = '{1,0,0,16'h0000,16'h1234, 16'h0032,16'h0000,16'h0000,0,1};
`else
    vt[10] = '{0,0,0,16'h0000,16'hF000, 16'h0034,16'hF000,16'h0032,1,0};
    vt[11] = '{0,0,0,16'h0000,16'h1234, 16'h0036,16'h1234,16'h0034,1,0};
    vt[12] = '{1,0,0,16'h0000,16'h1234, 16'h0036,16'h1234,16'h0034,1,0};
`endif
    vt[13] = '{0,0,1,16'h0000,16'h1234, 16'h0000,16'h0000,16'h0000,0,0};
    vt[14] = '{0,0,1,16'hFFFF,16'h4444, 16'hFFFE,16'h0000,16'h0000,0,0};
    vt[15] = '{0,0,0,16'h0000,16'h5678, 16'h0000,16'h5678,16'hFFFE,1,0};
    vt[16] = '{0,0,0,16'h0000,16'h9999, 16'h0002,16'h9999,16'h0000,1,0};
    vt[17] = '{1,1,0,16'h0000,16'h3333, 16'h0002,16'h0000,16'h0000,0,0};
    vt[18] = '{0,1,1,16'h000E,16'h3333, 16'h000E,16'h0000,16'h0000,0,0};
    vt[19] = '{0,0,0,16'h0000,16'h2222, 16'h0010,16'h2222,16'h000E,1,0};

    rst       = 1'b0;
    stall     = 1'b0;
    flush     = 1'b0;
    br_taken  = 1'b0;
    br_target = 16'h0000;
    {mem.one, mem.two, mem.three, mem.four} = 16'h012F;

    #12;
    chk("rst_pc", 32'(mem.pc), 32'h0000);
    chk("rst_id", 32'(ids()), 32'h0000);
    chk("rst_idpc", 32'(id_pc), 32'h0000);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      stall     = vt[i].st;
      flush     = vt[i].fl;
      br_taken  = vt[i].br;
      br_target = vt[i].tgt;
      {mem.one, mem.two, mem.three, mem.four} = vt[i].nib;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_pc", i), 32'(mem.pc), 32'(vt[i].e_pc));
      chk($sformatf("v%0d_id", i), 32'(ids()), 32'(vt[i].e_id));
      chk($sformatf("v%0d_idpc", i), 32'(id_pc), 32'(vt[i].e_idpc));
      chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vt[i].e_v));
      chk($sformatf("v%0d_halted", i), 32'(halted), 32'(vt[i].e_h));
    end

    // asynchronous reset between edges at pc=0x0010
    stall    = 1'b0;
    flush    = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_pc", 32'(mem.pc), 32'h0000);
    chk("arst_valid", 32'(id_valid), 32'h0);
    chk("arst_idpc", 32'(id_pc), 32'h0000);
    chk("arst_id", 32'(ids()), 32'h0000);
    chk("arst_halted", 32'(halted), 32'h0);

    // held reset ignores edges, then release refetches from PC_RESET
    {mem.one, mem.two, mem.three, mem.four} = 16'h6789;
    @(posedge clk);
    #1;
    chk("hold_pc", 32'(mem.pc), 32'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("refetch_id", 32'(ids()), 32'h6789);
    chk("refetch_pc", 32'(mem.pc), 32'h0002);
    chk("refetch_valid", 32'(id_valid), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
